// File: rtl/pwm_breathe_env_pkg.sv
// Shared types and constants for the breathing-envelope generator.
package pwm_pkg;

   localparam int DUTY_W = 6;

   typedef enum logic [2:0] {
      IDLE,
      RISE,
      HOLD_HI,
      FALL,
      HOLD_LO
   } breathe_state_t;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pwm_breathe_env_if.sv
// Duty-path bundle between the PWM control side and the envelope generator.
interface pwm_breathe_env_if #(
   parameter int DUTY_W = pwm_pkg::DUTY_W
) ();

   logic [DUTY_W-1:0] ref_in;       // static duty reference / breathing peak
   logic              breathe_en;   // breathing mode select
   logic              period_wrap;  // one-cycle strobe at PWM period rollover
   logic [DUTY_W-1:0] duty_out;     // duty presented to the PWM comparator
   logic              dir_up;
   logic              at_peak;

   modport master (
      output ref_in, breathe_en, period_wrap,
      input  duty_out, dir_up, at_peak
   );

   modport slave (
      input  ref_in, breathe_en, period_wrap,
      output duty_out, dir_up, at_peak
   );

endinterface

// File: rtl/pwm_breathe_env_tick_divider.sv
// Modulo-N event counter: advances on en, flags its terminal count, clr wins.
module tick_divider
   import pwm_pkg::*;
#(
   parameter int N = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic last      // count sits at N-1; the next advance wraps to 0
);

   localparam int            CW       = cnt_width(N);
   localparam logic [CW-1:0] LAST_VAL = CW'(N - 1);

   logic [CW-1:0] count;

   assign last = (count == LAST_VAL);

   // Count advance/clear; wraps to zero after the terminal value.
   // NOTE: clocked state is written with <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= last ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/pwm_breathe_env.sv
// Breathing envelope: reshapes the static duty reference into a triangle
// (0 -> peak -> 0 with holds) and only ever changes duty at PWM period wraps.
module pwm_breathe_env
   import pwm_pkg::*;
#(
   parameter int DUTY_W       = pwm_pkg::DUTY_W,
   parameter int STEP_PERIODS = 4,
   parameter int HOLD_PERIODS = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   pwm_breathe_env_if.slave bus
);

   breathe_state_t    state;
   logic [DUTY_W-1:0] duty;
   logic              dir_up_q;
   logic              at_peak_q;

   logic              tick;        // one evaluation slot per PWM period
   logic              breathing;   // tick with breathing still requested
   logic              step_last;
   logic              hold_last;
   logic              step_en, step_clr;
   logic              hold_en, hold_clr;
   logic [DUTY_W:0]   duty_inc;    // one bit wider so the compare never wraps
   logic              rise_top;
   logic [DUTY_W-1:0] fall_next;

   assign tick      = ena & bus.period_wrap;
   assign breathing = tick & bus.breathe_en;
   assign duty_inc  = {1'b0, duty} + 1'b1;
   assign rise_top  = (duty_inc >= {1'b0, bus.ref_in});

   // Next falling duty: clamp to a lowered peak, otherwise step down, floor at 0.
   // NOTE: every signal gets a default first so no path through the block infers a latch.
   always_comb begin
      fall_next = '0;
      if (duty > bus.ref_in) begin
         fall_next = bus.ref_in;
      end else if (duty != '0) begin
         fall_next = duty - 1'b1;
      end
   end

   // Counter control: clear on entry to a timed state, advance while inside it.
   always_comb begin
      step_en  = 1'b0;
      step_clr = 1'b0;
      hold_en  = 1'b0;
      hold_clr = 1'b0;
      if (breathing) begin
         step_en  = (state == RISE) || (state == FALL);
         hold_en  = (state == HOLD_HI) || (state == HOLD_LO);
         step_clr = (state == IDLE) || (hold_en && hold_last);
         hold_clr = step_last && (((state == RISE) && rise_top) ||
                                  ((state == FALL) && (fall_next == '0)));
      end
   end

   tick_divider #(.N(STEP_PERIODS)) u_step (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (step_en),
      .clr  (step_clr),
      .last (step_last)
   );

   tick_divider #(.N(HOLD_PERIODS)) u_hold (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (hold_en),
      .clr  (hold_clr),
      .last (hold_last)
   );

   // Envelope state machine with registered duty, direction and peak flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         duty      <= '0;
         dir_up_q  <= 1'b1;
         at_peak_q <= 1'b0;
      end else if (tick) begin
         if ((state != IDLE) && !bus.breathe_en) begin
            state     <= IDLE;
            duty      <= bus.ref_in;
            dir_up_q  <= 1'b1;
            at_peak_q <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.breathe_en) begin
                     state <= RISE;
                     duty  <= '0;
                  end else begin
                     duty  <= bus.ref_in;
                  end
               end
               RISE: begin
                  if (step_last) begin
                     if (rise_top) begin
                        state     <= HOLD_HI;
                        duty      <= bus.ref_in;
                        dir_up_q  <= 1'b0;
                        at_peak_q <= 1'b1;
                     end else begin
                        duty <= duty_inc[DUTY_W-1:0];
                     end
                  end
               end
               HOLD_HI: begin
                  duty <= bus.ref_in;
                  if (hold_last) begin
                     state     <= FALL;
                     at_peak_q <= 1'b0;
                  end
               end
               FALL: begin
                  if (step_last) begin
                     duty <= fall_next;
                     if (fall_next == '0) begin
                        state    <= HOLD_LO;
                        dir_up_q <= 1'b1;
                     end
                  end
               end
               HOLD_LO: begin
                  duty <= '0;
                  if (hold_last) begin
                     state <= RISE;
                  end
               end
               default: begin
                  state     <= IDLE;
                  duty      <= '0;
                  dir_up_q  <= 1'b1;
                  at_peak_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.duty_out = duty;
   assign bus.dir_up   = dir_up_q;
   assign bus.at_peak  = at_peak_q;

endmodule

// File: tb/tb_pwm_breathe_env.sv
// Self-checking bench for pwm_breathe_env: constant vector table for the
// documented sequences plus a tick-level reference model for random stimulus.
module tb_pwm_breathe_env;
   import pwm_pkg::*;

   localparam int STEP = 2;
   localparam int HOLD = 3;

   localparam int P_IDLE = 0;
   localparam int P_RISE = 1;
   localparam int P_HI   = 2;
   localparam int P_FALL = 3;
   localparam int P_LO   = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic ena;

   pwm_breathe_env_if #(.DUTY_W(DUTY_W)) bus ();

   pwm_breathe_env #(
      .DUTY_W      (DUTY_W),
      .STEP_PERIODS(STEP),
      .HOLD_PERIODS(HOLD)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .ena  (ena),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: phase, ticks spent in the phase, current duty.
   int m_phase = P_IDLE;
   int m_n     = 0;
   int m_duty  = 0;

   typedef struct {
      bit ena;
      bit wrap;
      bit be;
      int r;
      int duty;
      bit dir;
      bit pk;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got duty=%0d dir_up=%b at_peak=%b, expected duty=%0d dir_up=%b at_peak=%b",
                  name, got[7:2], got[1], got[0], exp[7:2], exp[1], exp[0]);
      end
   endtask

   function automatic logic [7:0] dut_out();
      return {bus.duty_out, bus.dir_up, bus.at_peak};
   endfunction

   function automatic logic [7:0] model_out();
      logic up;
      up = (m_phase == P_IDLE) || (m_phase == P_RISE) || (m_phase == P_LO);
      return {6'(m_duty), up, (m_phase == P_HI)};
   endfunction

   function automatic logic [7:0] pack(input int d, input bit dir, input bit pk);
      return {6'(d), dir, pk};
   endfunction

   task automatic model_reset();
      m_phase = P_IDLE;
      m_n     = 0;
      m_duty  = 0;
   endtask

   // One period-wrap evaluation of the envelope rules.
   task automatic model_tick(input int r, input bit be);
      if (m_phase != P_IDLE && !be) begin
         m_phase = P_IDLE;
         m_duty  = r;
         return;
      end
      case (m_phase)
         P_IDLE: begin
            if (be) begin
               m_phase = P_RISE;
               m_n     = 0;
               m_duty  = 0;
            end else begin
               m_duty = r;
            end
         end
         P_RISE: begin
            if (m_n % STEP == STEP - 1) begin
               if (m_duty + 1 >= r) begin
                  m_duty  = r;
                  m_phase = P_HI;
                  m_n     = 0;
                  return;
               end
               m_duty = m_duty + 1;
            end
            m_n++;
         end
         P_HI: begin
            m_duty = r;
            if (m_n == HOLD - 1) begin
               m_phase = P_FALL;
               m_n     = 0;
            end else begin
               m_n++;
            end
         end
         P_FALL: begin
            if (m_n % STEP == STEP - 1) begin
               m_duty = (m_duty > r) ? r : ((m_duty > 0) ? m_duty - 1 : 0);
               if (m_duty == 0) begin
                  m_phase = P_LO;
                  m_n     = 0;
                  return;
               end
            end
            m_n++;
         end
         P_LO: begin
            m_duty = 0;
            if (m_n == HOLD - 1) begin
               m_phase = P_RISE;
               m_n     = 0;
            end else begin
               m_n++;
            end
         end
         default: ;
      endcase
   endtask

   // Apply inputs, let one rising edge pass, advance the model, settle 1 ns.
   task automatic cycle(input bit e, input bit w, input bit be, input int r);
      ena             = e;
      bus.period_wrap = w;
      bus.breathe_en  = be;
      bus.ref_in      = 6'(r);
      @(posedge clk);
      if (e && w && rst_n) model_tick(r, be);
      #1;
   endtask

   task automatic add(input bit e, input bit w, input bit be, input int r,
                      input int d, input bit dir, input bit pk);
      vec_t v;
      v.ena = e; v.wrap = w; v.be = be; v.r = r; v.duty = d; v.dir = dir; v.pk = pk;
      vecs.push_back(v);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      cycle(1'b1, 1'b0, 1'b0, 0);
      rst_n = 1'b1;
   endtask

   initial begin
      bit found;
      bit be_r;
      int ref_r;
      logic [7:0] snap;

      rst_n           = 1'b0;
      ena             = 1'b1;
      bus.ref_in      = 6'd20;
      bus.breathe_en  = 1'b1;
      bus.period_wrap = 1'b0;
      model_reset();

      // Reset holds outputs regardless of strobes and breathing request.
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b1, 1'b1, 20);
         check("reset", dut_out(), pack(0, 1'b1, 1'b0));
      end
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 1'b0, 1'b1, 20);
         check("post_reset_no_tick", dut_out(), pack(0, 1'b1, 1'b0));
      end

      // Pass-through, strobe gating, then the STEP=2/HOLD=3 triangle at peak 4.
      add(1, 1, 0, 6, 6, 1, 0);
      add(1, 0, 0, 9, 6, 1, 0);
      add(0, 1, 0, 9, 6, 1, 0);
      add(1, 1, 0, 9, 9, 1, 0);
      add(1, 1, 0, 4, 4, 1, 0);
      add(1, 1, 1, 4, 0, 1, 0);
      add(1, 1, 1, 4, 0, 1, 0);
      add(1, 0, 1, 4, 0, 1, 0);
      add(1, 1, 1, 4, 1, 1, 0);
      add(1, 1, 1, 4, 1, 1, 0);
      add(1, 1, 1, 4, 2, 1, 0);
      add(1, 1, 1, 4, 2, 1, 0);
      add(1, 1, 1, 4, 3, 1, 0);
      add(1, 1, 1, 4, 3, 1, 0);
      add(1, 1, 1, 4, 4, 0, 1);
      add(1, 1, 1, 4, 4, 0, 1);
      add(1, 1, 1, 4, 4, 0, 1);
      add(1, 1, 1, 4, 4, 0, 0);
      add(1, 1, 1, 4, 4, 0, 0);
      add(1, 1, 1, 4, 3, 0, 0);
      add(1, 1, 1, 4, 3, 0, 0);
      add(1, 1, 1, 4, 2, 0, 0);
      add(1, 1, 1, 4, 2, 0, 0);
      add(1, 1, 1, 4, 1, 0, 0);
      add(1, 1, 1, 4, 1, 0, 0);
      add(1, 1, 1, 4, 0, 1, 0);
      add(1, 1, 1, 4, 0, 1, 0);
      add(1, 1, 1, 4, 0, 1, 0);
      add(1, 1, 1, 4, 0, 1, 0);
      add(1, 1, 1, 4, 0, 1, 0);
      add(1, 1, 1, 4, 1, 1, 0);
      add(1, 1, 0, 11, 11, 1, 0);

      foreach (vecs[i]) begin
         cycle(vecs[i].ena, vecs[i].wrap, vecs[i].be, vecs[i].r);
         check($sformatf("vec%0d", i), dut_out(), pack(vecs[i].duty, vecs[i].dir, vecs[i].pk));
      end

      // Peak lowered mid-rise: clamp on the next step and enter peak hold.
      do_reset();
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         cycle(1'b1, 1'b1, 1'b1, 32);
         check("rise_to_10", dut_out(), model_out());
         found = (m_phase == P_RISE) && (m_duty == 10);
      end
      if (!found) check("rise_to_10_timeout", 8'hFF, 8'h00);
      cycle(1'b1, 1'b1, 1'b1, 5);
      check("peak_drop_wait", dut_out(), pack(10, 1'b1, 1'b0));
      cycle(1'b1, 1'b1, 1'b1, 5);
      check("peak_drop_clamp", dut_out(), pack(5, 1'b0, 1'b1));

      // Leave breathing mid-fall: duty jumps to the reference on that tick.
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         cycle(1'b1, 1'b1, 1'b1, 16);
         check("fall_to_7", dut_out(), model_out());
         found = (m_phase == P_FALL) && (m_duty == 7);
      end
      if (!found) check("fall_to_7_timeout", 8'hFF, 8'h00);
      cycle(1'b1, 1'b1, 1'b0, 16);
      check("exit_mid_fall", dut_out(), pack(16, 1'b1, 1'b0));
      cycle(1'b1, 1'b1, 1'b0, 16);
      check("idle_after_exit", dut_out(), pack(16, 1'b1, 1'b0));

      // Freeze with ena=0 mid-rise, then resume on the exact same schedule.
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         cycle(1'b1, 1'b1, 1'b1, 30);
         check("rise_to_3", dut_out(), model_out());
         found = (m_phase == P_RISE) && (m_duty == 3);
      end
      if (!found) check("rise_to_3_timeout", 8'hFF, 8'h00);
      cycle(1'b1, 1'b1, 1'b1, 30);
      snap = model_out();
      for (int i = 0; i < 20; i++) begin
         cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 63)));
         check("ena_freeze", dut_out(), snap);
      end
      for (int i = 0; i < 12; i++) begin
         cycle(1'b1, 1'b1, 1'b1, 30);
         check("ena_resume", dut_out(), model_out());
      end

      // Random ticks, gaps, reference changes (incl. 0 and max) and mode toggles.
      be_r  = 1'b1;
      ref_r = 12;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 39) == 0) be_r = ~be_r;
         if ($urandom_range(0, 29) == 0) begin
            case ($urandom_range(0, 3))
               0:       ref_r = 0;
               1:       ref_r = 63;
               default: ref_r = int'($urandom_range(0, 63));
            endcase
         end
         cycle(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 2) != 0), be_r, ref_r);
         check("random", dut_out(), model_out());
      end

      // Asynchronous reset mid-sequence, then an IDLE-first tick.
      for (int i = 0; i < 15; i++) begin
         cycle(1'b1, 1'b1, 1'b1, 9);
      end
      rst_n = 1'b0;
      model_reset();
      #2;
      check("async_reset", dut_out(), pack(0, 1'b1, 1'b0));
      cycle(1'b1, 1'b1, 1'b1, 9);
      rst_n = 1'b1;
      cycle(1'b1, 1'b1, 1'b0, 13);
      check("post_reset_tick", dut_out(), pack(13, 1'b1, 1'b0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pwm_breathe_env.md
# pwm_breathe_env

Breathing-envelope generator sitting directly upstream of the PWM comparator in the top-level PWM design. It turns the static 6-bit duty reference into a triangle-shaped duty sequence (0 → peak → 0, with holds) when breathing mode is on, and passes the reference through when it is off. All duty updates are aligned to PWM period boundaries, so the comparator never sees a mid-period duty change.

## Interface
Parameters:
- DUTY_W, 6, width of duty reference and output
- STEP_PERIODS, 4, PWM periods per ±1 duty step (≥1)
- HOLD_PERIODS, 16, PWM periods held at peak and at zero (≥1)

Ports:
- clk  in  1  system clock (single clock domain)
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  design enable; when 0, all counters and state freeze, outputs hold
- ref_in  in  DUTY_W  duty reference / breathing peak (from ui_in[5:0])
- breathe_en  in  1  breathing mode select (from ui_in[6])
- period_wrap  in  1  one-cycle strobe from PWM counter on period rollover
- duty_out  out  DUTY_W  registered duty to PWM comparator
- dir_up  out  1  1 while rising or holding at zero, 0 while falling or holding at peak
- at_peak  out  1  1 in HOLD_HI state

## Operation
- States: IDLE, RISE, HOLD_HI, FALL, HOLD_LO. Only evaluated on cycles with ena=1 and period_wrap=1 ("tick"); otherwise all registers hold.
- IDLE: duty_out ← ref_in each tick. If breathe_en=1 at a tick: duty_out ← 0, step_cnt ← 0, go RISE.
- RISE: step_cnt increments each tick; when step_cnt = STEP_PERIODS-1, step_cnt ← 0 and duty_out ← duty_out+1. When duty_out+1 ≥ ref_in (or duty_out already ≥ ref_in), duty_out ← ref_in, hold_cnt ← 0, go HOLD_HI.
- HOLD_HI: hold_cnt increments each tick; at HOLD_PERIODS-1 go FALL, step_cnt ← 0. Peak tracks ref_in: duty_out ← ref_in each tick.
- FALL: mirror of RISE, decrement; at duty_out = 1 step or duty_out = 0 → duty_out ← 0, go HOLD_LO.
- HOLD_LO: duty_out = 0; after HOLD_PERIODS ticks go RISE.
- breathe_en=0 sampled at any tick in any non-IDLE state: go IDLE, duty_out ← ref_in on that same tick.
- ref_in drops below duty_out during RISE/FALL: duty_out clamped to ref_in on next step; RISE transitions to HOLD_HI.
- ref_in = 0 with breathe_en=1: sequence runs with duty_out permanently 0; no underflow/overflow.
- Arithmetic unsigned, DUTY_W bits, saturating at 0 and ref_in; never wraps.
- dir_up=1 in IDLE, RISE, HOLD_LO; 0 in HOLD_HI, FALL. at_peak=1 only in HOLD_HI.

## Timing
- Reset (async assert, sync-safe release): state IDLE, duty_out=0, step_cnt=0, hold_cnt=0, dir_up=1, at_peak=0.
- Latency: duty_out/dir_up/at_peak update on the clk edge that samples period_wrap=1; visible the cycle after the strobe.
- period_wrap is a single-cycle pulse; back-to-back pulses are each a tick.
- Reset mid-sequence: immediate return to reset values; first post-reset tick behaves as IDLE.
- Full triangle period with peak P: 2·P·STEP_PERIODS + 2·HOLD_PERIODS ticks (±1 for clamp step).

## Structure
- Package pwm_pkg: DUTY_W constant, state enum breathe_state_t (IDLE, RISE, HOLD_HI, FALL, HOLD_LO).
- One sub-module: tick_divider — generic modulo-N tick counter with clear, instanced for step_cnt and hold_cnt.
- Outputs fully registered; no combinational path input → output.

## Test plan
- Reset: rst_n=0 with ref_in=20, breathe_en=1 → duty_out=0, dir_up=1, at_peak=0; hold 5 ticks after release in IDLE-first behaviour.
- Pass-through: breathe_en=0, ref_in=6, pulse period_wrap → duty_out=6 one cycle after strobe; no change without strobe.
- Triangle: ref_in=4, STEP_PERIODS=2, HOLD_PERIODS=3 → duty 0,0,1,1,2,2,3,3,4 then 4×3, then 3,3,2,2,1,1,0 then 0×3, repeat; at_peak=1 exactly during peak hold.
- Peak change: mid-RISE at duty 10 with ref_in dropped 32→5 → next step duty_out=5, state HOLD_HI.
- Exit mid-fall: breathe_en 1→0 at duty 7, ref_in=16 → duty_out=16 on that tick, state IDLE.
- ena=0 for 20 strobes mid-RISE → duty_out and counters frozen; resumes exactly where stopped.
